sram_arbiter: RTL

- Synchronous controller sharing the single asynchronous sram model between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write).
- Registers all sram strobes and address/data, holds them stable for a programmable number of wait states, captures read data and returns a one-cycle ack.
- Sits between the IF/MEM stages and the sram instance.

---
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: pipeline-side request/ack bundle for sram_arbiter.
// The master side is the IF/MEM pipeline, the slave side is the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_rdata, i_ack, d_rdata, d_ack
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_rdata, i_ack, d_rdata, d_ack
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous sram between the instruction-fetch
// port (read-only) and the data port (read/write). Every sram strobe,
// address and write datum comes from a register and is held for
// WAIT_CYCLES+1 cycles. Read data is captured on the last ACCESS cycle and
// the winner gets a one-cycle ack in DONE.
// Optional build macro SRAM_ARB_RR_EN: on a tie, grant the port that was
// not served last. Without it, the data port always wins a tie.
module sram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);
  localparam logic       GRANT_I   = 1'b0;
  localparam logic       GRANT_D   = 1'b1;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_grant, w_grant_nxt;   // owner of the current transaction
  logic              r_wr, w_wr_nxt;         // current transaction is a write
  logic              r_cs, w_cs_nxt;
  logic              r_oe, w_oe_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_i_ack, w_i_ack_nxt;
  logic              r_d_ack, w_d_ack_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_pick_d;
`ifdef SRAM_ARB_RR_EN
  logic              r_last_grant, w_last_grant_nxt;
`endif

  // Arbitration: decide which pending request would win the IDLE slot
  always_comb begin
    w_pick_d = GRANT_I;
    if (bus.d_req && bus.i_req) begin
`ifdef SRAM_ARB_RR_EN
      w_pick_d = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
      w_pick_d = GRANT_D;
`endif
    end else if (bus.d_req) begin
      w_pick_d = GRANT_D;
    end else begin
      w_pick_d = GRANT_I;
    end
  end

  // Next-state and next-register values for the IDLE/ACCESS/DONE sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_wr_nxt      = r_wr;
    w_cs_nxt      = r_cs;
    w_oe_nxt      = r_oe;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    w_i_ack_nxt   = 1'b0;
    w_d_ack_nxt   = 1'b0;
`ifdef SRAM_ARB_RR_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = WAIT_INIT;
          w_grant_nxt = w_pick_d;
          if (w_pick_d == GRANT_D) begin
            w_wr_nxt   = bus.d_we;
            w_addr_nxt = bus.d_addr;
            w_din_nxt  = bus.d_wdata;
          end else begin
            w_wr_nxt   = 1'b0;
            w_addr_nxt = bus.i_addr;
            w_din_nxt  = r_din;
          end
          w_cs_nxt = 1'b1;
          w_oe_nxt = ~w_wr_nxt;
          w_we_nxt = w_wr_nxt;
        end else begin
          w_cs_nxt = 1'b0;
          w_oe_nxt = 1'b0;
          w_we_nxt = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          // Last strobe cycle: sram_dout has settled on the held address
          w_state_nxt = ST_DONE;
          w_cs_nxt    = 1'b0;
          w_oe_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
          w_i_ack_nxt = (r_grant == GRANT_I);
          w_d_ack_nxt = (r_grant == GRANT_D);
          if (!r_wr) begin
            if (r_grant == GRANT_D) begin
              w_d_rdata_nxt = sram_dout;
            end else begin
              w_i_rdata_nxt = sram_dout;
            end
          end else begin
            w_d_rdata_nxt = r_d_rdata;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
`ifdef SRAM_ARB_RR_EN
        w_last_grant_nxt = r_grant;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b0;
        w_oe_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_grant   <= GRANT_I;
      r_wr      <= 1'b0;
      r_cs      <= 1'b0;
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      r_last_grant <= GRANT_I;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_wr      <= w_wr_nxt;
      r_cs      <= w_cs_nxt;
      r_oe      <= w_oe_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_i_ack   <= w_i_ack_nxt;
      r_d_ack   <= w_d_ack_nxt;
      r_busy    <= w_busy_nxt;
`ifdef SRAM_ARB_RR_EN
      r_last_grant <= w_last_grant_nxt;
`endif
    end
  end

  assign sram_cs     = r_cs;
  assign sram_oe     = r_oe;
  assign sram_we     = r_we;
  assign sram_addr   = r_addr;
  assign sram_din    = r_din;
  assign busy        = r_busy;
  assign bus.i_rdata = r_i_rdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.d_rdata = r_d_rdata;
  assign bus.d_ack   = r_d_ack;

endmodule
